sample_capture: RTL and testbench
=================================

# sample_capture

Trigger-and-capture stage sitting directly upstream of the 512-point filter. Takes the ADC sample stream, waits for a level/edge trigger, records a 512-sample frame with a programmable pre-trigger portion into an internal ring buffer, then unrolls that frame in time order into a 512×12 output array. The filter and display consume the array once `frame_valid` is asserted.

## Interface
- `DEPTH`, 512: frame length. Fixed at 512 to match the filter input. Pointers are 9 bits.
- `PRE_SAMPLES`, 128: samples kept before the trigger point. Legal range is 0..DEPTH-1.
- `TIMEOUT`, 1_000_000: number of `adc_valid` strobes waited before a forced trigger. Used only with `AUTO_TRIG_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `adc_data`  in  12  sample, two's complement.
- `adc_valid`  in  1  one-cycle strobe qualifying `adc_data`.
- `arm`  in  1  pulse that starts a capture.
- `trig_level`  in  12  signed trigger threshold.
- `trig_edge`  in  1  0 = rising, 1 = falling.
- `data`  out  12 × [0:511]  captured frame. Index 0 is the oldest sample.
- `frame_valid`  out  1  high while `data` holds a complete, stable frame.
- `busy`  out  1  high in every state except IDLE and DONE.
- `trig_forced`  out  1  the last frame was captured on timeout, not on a real edge.

## Operation
- Storage is an internal ring buffer `mem[0:511]` with a 9-bit write pointer `wp` that wraps from 511 to 0.
- FSM states: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, COPY, DONE.
- IDLE or DONE + `arm`:
  - go to PRE_FILL;
  - clear `frame_valid`, `trig_forced`, the fill counter and `prev`;
  - `arm` is ignored in every other state.
- PRE_FILL:
  - each `adc_valid` writes `mem[wp]`, increments `wp` and the fill counter, and loads `prev`;
  - leave for WAIT_TRIG once PRE_SAMPLES samples are stored;
  - with PRE_SAMPLES = 0, go straight to WAIT_TRIG.
- WAIT_TRIG:
  - keep writing the ring on each `adc_valid`;
  - rising trigger: signed `prev < trig_level` and `adc_data >= trig_level`;
  - falling trigger: `prev > trig_level` and `adc_data <= trig_level`;
  - `prev` is not valid before the first sample after arming, so no trigger is possible on that sample.
- Trigger sample:
  - it is written to the ring and counts as post-sample 1;
  - latch `start = wp - PRE_SAMPLES` (mod 512), using `wp` before its increment;
  - go to POST_FILL.
- POST_FILL:
  - store samples until DEPTH - PRE_SAMPLES post-samples exist, including the trigger sample;
  - then go to COPY.
- COPY:
  - one entry per clock: `data[i] <= mem[start + i]` for i = 0..511, independent of `adc_valid`;
  - after i = 511 go to DONE.
- DONE: `frame_valid` = 1 and `data` holds until the next `arm`.
- Result: the trigger sample always sits at `data[PRE_SAMPLES]`.
- Samples arriving during COPY or DONE are dropped.

## Timing
- Reset (asynchronous):
  - state = IDLE; `data` all 0; `frame_valid` = 0; `busy` = 0; `trig_forced` = 0;
  - `wp` = 0 and `prev` = 0.
- A reset mid-capture aborts the capture immediately and discards any partial frame.
- `arm` is sampled on a `clk` edge. `busy` rises on the next edge.
- If `arm` and `adc_valid` coincide, the sample is taken in PRE_FILL on the following cycle. The coincident sample is not stored.
- Ring and `prev` update on the same edge as the `adc_valid` that carries the sample.
- Trigger evaluation is combinational on the current `adc_data` against the registered `prev`. The state change happens on that same edge.
- COPY takes exactly 512 cycles.
- `frame_valid` rises on the edge after `data[511]` is written. It stays 0 throughout COPY.
- End-to-end latency from the last post-sample to `frame_valid` is 513 cycles.
- Back-to-back `adc_valid` on every cycle is supported. There are no gaps or stalls.

## Configuration
- `AUTO_TRIG_EN` defined:
  - WAIT_TRIG counts `adc_valid` strobes;
  - after TIMEOUT strobes without an edge, the current sample is treated as the trigger sample and `trig_forced` is set to 1;
  - the counter clears on entry to WAIT_TRIG.
- `AUTO_TRIG_EN` undefined: the timeout counter is absent, `trig_forced` is tied to 0, and WAIT_TRIG waits indefinitely.

## Test plan
- Rising-edge capture:
  - stimulus: `arm`, then a ramp −1000, −999, …; `trig_level` = 0; `trig_edge` = 0; PRE_SAMPLES = 128;
  - response: `data[128]` = 0, `data[127]` = −1, `data[0]` = −128, `data[511]` = 383, and `frame_valid` rises 513 cycles after the last post-sample.
- Falling edge with ring wrap:
  - stimulus: stay in WAIT_TRIG for 700 samples of +500, then step to −500; `trig_level` = 0; `trig_edge` = 1;
  - response: `data[0..127]` = 500 and `data[128..511]` = −500, which checks that the start index wraps correctly.
- Level not crossed:
  - stimulus: `adc_data` held at `trig_level` for 10k samples;
  - response: no trigger (equality on both sides is not a crossing), `busy` = 1, `frame_valid` = 0.
- Reset mid-POST_FILL:
  - stimulus: assert `rst` during POST_FILL;
  - response: outputs go to their reset values without waiting for a clock edge, and a later `arm` produces a clean new frame.
- `arm` during COPY:
  - response: it is ignored, and the frame completes unchanged.
- `AUTO_TRIG_EN` with TIMEOUT = 50:
  - stimulus: constant input;
  - response: forced trigger on the 50th strobe in WAIT_TRIG and `trig_forced` = 1.

Source files
------------

// File: rtl/sample_capture.sv
// sample_capture: trigger-and-capture of a 512-sample frame via a pre-trigger ring buffer; define AUTO_TRIG_EN to force a trigger after TIMEOUT strobes
module sample_capture #(
  parameter int DEPTH       = 512,
  parameter int PRE_SAMPLES = 128,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic        arm,
  input  logic [11:0] trig_level,
  input  logic        trig_edge,
  output logic [11:0] data [0:DEPTH-1],
  output logic        frame_valid,
  output logic        busy,
  output logic        trig_forced
);
  localparam int PW   = $clog2(DEPTH);
  localparam int POST = DEPTH - PRE_SAMPLES;
  typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, COPY, DONE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] wp_q, wp_d, start_q, start_d, idx_q, idx_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [11:0]   prev_q, prev_d;
  logic          prev_ok_q, prev_ok_d, frame_valid_q, frame_valid_d;
  logic          busy_q, busy_d, trig_forced_q, trig_forced_d;
  logic          we, edge_hit, timeout_hit;
  logic [11:0]   mem [0:DEPTH-1];
  // prev only qualifies a crossing once a sample has been seen since arming
  assign edge_hit = prev_ok_q && (trig_edge
    ? ($signed(prev_q) > $signed(trig_level) && $signed(adc_data) <= $signed(trig_level))
    : ($signed(prev_q) < $signed(trig_level) && $signed(adc_data) >= $signed(trig_level)));
`ifdef AUTO_TRIG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign timeout_hit = adc_valid && tmo_q == TW'(TIMEOUT - 1);
  // strobe counter lives only in WAIT_TRIG, so it is zero on every entry
  always_comb tmo_d = state_q != WAIT_TRIG ? '0 : adc_valid ? tmo_q + 1'b1 : tmo_q;
  // timeout counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign timeout_hit = 1'b0;
`endif
  // next-state and datapath control for the capture sequence
  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    cnt_d         = cnt_q;
    prev_d        = prev_q;
    prev_ok_d     = prev_ok_q;
    start_d       = start_q;
    idx_d         = idx_q;
    frame_valid_d = frame_valid_q;
    trig_forced_d = trig_forced_q;
    we            = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        frame_valid_d = state_q == DONE && !arm;
        if (arm) begin
          state_d       = PRE_SAMPLES == 0 ? WAIT_TRIG : PRE_FILL;
          trig_forced_d = 1'b0;
          cnt_d         = '0;
          prev_d        = '0;
          prev_ok_d     = 1'b0;
        end
      end
      PRE_FILL: if (adc_valid) begin
        we        = 1'b1;
        wp_d      = wp_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        prev_d    = adc_data;
        prev_ok_d = 1'b1;
        if (cnt_q == (PW+1)'(PRE_SAMPLES - 1)) state_d = WAIT_TRIG;
      end
      WAIT_TRIG: if (adc_valid) begin
        we        = 1'b1;
        wp_d      = wp_q + 1'b1;
        prev_d    = adc_data;
        prev_ok_d = 1'b1;
        if (edge_hit || timeout_hit) begin
          start_d       = wp_q - PW'(PRE_SAMPLES);
          cnt_d         = (PW+1)'(1);
          idx_d         = '0;
          trig_forced_d = !edge_hit;
          state_d       = POST == 1 ? COPY : POST_FILL;
        end
      end
      POST_FILL: if (adc_valid) begin
        we     = 1'b1;
        wp_d   = wp_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        prev_d = adc_data;
        if (cnt_q == (PW+1)'(POST - 1)) state_d = COPY;
      end
      COPY: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == PW'(DEPTH - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy_d = state_d != IDLE && state_d != DONE;
  // control and status registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      wp_q          <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
      prev_ok_q     <= 1'b0;
      start_q       <= '0;
      idx_q         <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      trig_forced_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      prev_ok_q     <= prev_ok_d;
      start_q       <= start_d;
      idx_q         <= idx_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      trig_forced_q <= trig_forced_d;
    end
  // ring buffer write port
  always_ff @(posedge clk)
    if (we) mem[wp_q] <= adc_data;
  // unroll the ring into time order, one entry per clock
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    else if (state_q == COPY) data[idx_q] <= mem[start_q + idx_q];
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign trig_forced = trig_forced_q;
endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: directed tests for sample_capture (AUTO_TRIG_EN selects the forced-trigger test)
module tb_sample_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        arm = 1'b0;
  logic [11:0] trig_level = '0;
  logic        trig_edge = 1'b0;
  logic [11:0] data [0:511];
  logic        frame_valid, busy, trig_forced;
  int          checks = 0;
  int          errors = 0;

  sample_capture #(.DEPTH(512), .PRE_SAMPLES(128), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm),
    .trig_level(trig_level), .trig_edge(trig_edge), .data(data),
    .frame_valid(frame_valid), .busy(busy), .trig_forced(trig_forced)
  );

  always #5 clk = ~clk;

  task automatic sample(input int v);
    @(negedge clk);
    adc_data  = 12'(v);
    adc_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm       = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 12'(-2000);
    @(negedge clk);
    arm       = 1'b0;
    adc_valid = 1'b0;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_valid && n < 2000);
  endtask

  task automatic test_reset();
    #12;
    checks += 5;
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (trig_forced !== 1'b0) begin errors++; $display("FAIL reset_tf got %b want 0", trig_forced); end
    if (data[0] !== 12'd0) begin errors++; $display("FAIL reset_d0 got %h want 000", data[0]); end
    if (data[511] !== 12'd0) begin errors++; $display("FAIL reset_d511 got %h want 000", data[511]); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rising();
    int n;
    trig_level = 12'd0;
    trig_edge  = 1'b0;
    pulse_arm();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy got %b want 1", busy); end
    for (int i = 0; i < 1384; i++) sample(-1000 + i);
    idle();
    wait_frame(n);
    checks += 7;
    if (n != 513) begin errors++; $display("FAIL rise_latency got %0d want 513", n); end
    if (data[128] !== 12'(0)) begin errors++; $display("FAIL rise_d128 got %0d want 0", $signed(data[128])); end
    if (data[127] !== 12'(-1)) begin errors++; $display("FAIL rise_d127 got %0d want -1", $signed(data[127])); end
    if (data[0] !== 12'(-128)) begin errors++; $display("FAIL rise_d0 got %0d want -128", $signed(data[0])); end
    if (data[511] !== 12'(383)) begin errors++; $display("FAIL rise_d511 got %0d want 383", $signed(data[511])); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rise_busy_done got %b want 0", busy); end
    if (trig_forced !== 1'b0) begin errors++; $display("FAIL rise_tf got %b want 0", trig_forced); end
  endtask

  task automatic test_falling_wrap();
    int n, bad_pre, bad_post;
    trig_edge = 1'b1;
    pulse_arm();
    for (int i = 0; i < 828; i++) sample(500);
    for (int i = 0; i < 384; i++) sample(-500);
    idle();
    wait_frame(n);
    bad_pre  = 0;
    bad_post = 0;
    for (int i = 0; i < 128; i++) if (data[i] !== 12'(500)) bad_pre++;
    for (int i = 128; i < 512; i++) if (data[i] !== 12'(-500)) bad_post++;
    checks += 3;
    if (n != 513) begin errors++; $display("FAIL fall_latency got %0d want 513", n); end
    if (bad_pre != 0) begin errors++; $display("FAIL fall_pre got %0d bad entries want 0", bad_pre); end
    if (bad_post != 0) begin errors++; $display("FAIL fall_post got %0d bad entries want 0", bad_post); end
  endtask

  task automatic test_level_hold();
    trig_edge  = 1'b0;
    trig_level = 12'd100;
    pulse_arm();
    for (int i = 0; i < 10000; i++) sample(100);
    idle();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", busy); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_fv got %b want 0", frame_valid); end
  endtask

  task automatic test_reset_mid_post();
    sample(99);
    sample(100);
    for (int i = 0; i < 10; i++) sample(200 + i);
    @(negedge clk);
    #2;
    adc_valid = 1'b0;
    rst       = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fv got %b want 0", frame_valid); end
    if (trig_forced !== 1'b0) begin errors++; $display("FAIL rstmid_tf got %b want 0", trig_forced); end
    if (data[0] !== 12'd0) begin errors++; $display("FAIL rstmid_d0 got %0d want 0", $signed(data[0])); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arm_during_copy();
    int n;
    trig_edge  = 1'b0;
    trig_level = 12'(-50);
    pulse_arm();
    for (int i = 0; i < 634; i++) sample(-300 + i);
    idle();
    repeat (10) @(negedge clk);
    pulse_arm();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL copyarm_busy got %b want 1", busy); end
    wait_frame(n);
    repeat (5) @(negedge clk);
    checks += 6;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL copyarm_fv got %b want 1", frame_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL copyarm_busy_done got %b want 0", busy); end
    if (data[0] !== 12'(-178)) begin errors++; $display("FAIL copyarm_d0 got %0d want -178", $signed(data[0])); end
    if (data[128] !== 12'(-50)) begin errors++; $display("FAIL copyarm_d128 got %0d want -50", $signed(data[128])); end
    if (data[300] !== 12'(122)) begin errors++; $display("FAIL copyarm_d300 got %0d want 122", $signed(data[300])); end
    if (data[511] !== 12'(333)) begin errors++; $display("FAIL copyarm_d511 got %0d want 333", $signed(data[511])); end
  endtask

`ifdef AUTO_TRIG_EN
  task automatic test_auto_trig();
    int n;
    trig_edge  = 1'b0;
    trig_level = 12'd0;
    pulse_arm();
    for (int i = 0; i < 561; i++) sample(7);
    idle();
    wait_frame(n);
    checks += 2;
    if (n != 513) begin errors++; $display("FAIL auto_latency got %0d want 513", n); end
    if (trig_forced !== 1'b1) begin errors++; $display("FAIL auto_tf got %b want 1", trig_forced); end
  endtask
`else
  task automatic test_no_auto_trig();
    trig_edge  = 1'b0;
    trig_level = 12'd0;
    pulse_arm();
    for (int i = 0; i < 700; i++) sample(7);
    idle();
    repeat (600) @(negedge clk);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL noauto_busy got %b want 1", busy); end
    if (frame_valid !== 1'b0) begin errors++; $display("FAIL noauto_fv got %b want 0", frame_valid); end
    if (trig_forced !== 1'b0) begin errors++; $display("FAIL noauto_tf got %b want 0", trig_forced); end
  endtask
`endif

  initial begin
    test_reset();
    test_rising();
    test_falling_wrap();
    test_level_hold();
    test_reset_mid_post();
    test_arm_during_copy();
`ifdef AUTO_TRIG_EN
    test_auto_trig();
`else
    test_no_auto_trig();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
